// File: rtl/max31865_rtd_filter_if.sv
// Bus between the MAX31865 driver, the RTD filter and the system logic that consumes averages/faults.
// The driver side is "master"; the filter is "slave".
interface max31865_rtd_filter_if;
  logic [15:0]        rtd_data;
  logic               rtd_valid;
  logic               fault_clr;
  logic [14:0]        avg_code;
  logic signed [15:0] temp_x16;
  logic               avg_valid;
  logic               fault_latched;
  logic [7:0]         fault_cnt;

  modport master (
    output rtd_data, rtd_valid, fault_clr,
    input  avg_code, temp_x16, avg_valid, fault_latched, fault_cnt
  );

  modport slave (
    input  rtd_data, rtd_valid, fault_clr,
    output avg_code, temp_x16, avg_valid, fault_latched, fault_cnt
  );
endinterface

// File: rtl/max31865_rtd_filter.sv
// Screens faulty MAX31865 RTD reads, block-averages good ones over 2^AVG_LOG2 samples,
// converts each average to 1/16 degC and latches a fault after FAULT_LIMIT consecutive faults.
module max31865_rtd_filter #(
  parameter int AVG_LOG2    = 2,
  parameter int FAULT_LIMIT = 3
) (
  input logic                  clk,
  input logic                  rstn,
  max31865_rtd_filter_if.slave bus
);

  localparam int             AW      = 15 + AVG_LOG2;
  localparam int             CW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]     LIMIT   = 8'(FAULT_LIMIT);

  typedef enum logic {ACCUM, FAULTED} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    fcnt, fcnt_nxt;
  logic [14:0]   avg, avg_nxt;
  logic [15:0]   temp, temp_nxt;
  logic          vld, vld_nxt;

  logic [14:0]   code;
  logic          fault_bit;
  logic [AW-1:0] sum;
  logic [14:0]   sum_avg;
  logic [7:0]    fcnt_base;
  logic [7:0]    fcnt_inc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      fcnt  <= '0;
      avg   <= '0;
      temp  <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      fcnt  <= fcnt_nxt;
      avg   <= avg_nxt;
      temp  <= temp_nxt;
      vld   <= vld_nxt;
    end
  end

  // A clear arriving with a sample in ACCUM resets the fault count before the sample is judged.
  always_comb begin
    code      = bus.rtd_data[15:1];
    fault_bit = bus.rtd_data[0];
    sum       = acc + AW'(code);
    sum_avg   = 15'(sum >> AVG_LOG2);
    fcnt_base = bus.fault_clr ? 8'd0 : fcnt;
    fcnt_inc  = (fcnt_base >= LIMIT) ? LIMIT : fcnt_base + 8'd1;

    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt;
    avg_nxt   = avg;
    temp_nxt  = temp;
    vld_nxt   = 1'b0;

    case (state)
      ACCUM: begin
        fcnt_nxt = fcnt_base;
        if (bus.rtd_valid) begin
          if (!fault_bit) begin
            fcnt_nxt = 8'd0;
            if (cnt < CNT_MAX) begin
              acc_nxt = sum;
              cnt_nxt = cnt + 1'b1;
            end else begin
              avg_nxt  = sum_avg;
              temp_nxt = {2'b00, sum_avg[14:1]} - 16'd4096;
              acc_nxt  = '0;
              cnt_nxt  = '0;
              vld_nxt  = 1'b1;
            end
          end else begin
            fcnt_nxt = fcnt_inc;
            if (fcnt_inc == LIMIT) begin
              state_nxt = FAULTED;
              acc_nxt   = '0;
              cnt_nxt   = '0;
            end
          end
        end
      end
      FAULTED: begin
        if (bus.fault_clr) begin
          state_nxt = ACCUM;
          fcnt_nxt  = 8'd0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign bus.avg_code      = avg;
  assign bus.temp_x16      = temp;
  assign bus.avg_valid     = vld;
  assign bus.fault_latched = (state == FAULTED);
  assign bus.fault_cnt     = fcnt;

endmodule

// File: tb/tb_max31865_rtd_filter.sv
// Directed bench for max31865_rtd_filter: expected averages go into a scoreboard queue that a
// monitor drains on every avg_valid pulse; status outputs are checked directly after each sample.
module tb_max31865_rtd_filter;

  typedef struct {
    int avg;
    int temp;
  } exp_t;

  logic clk;
  logic rstn;
  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  max31865_rtd_filter_if bus ();

  max31865_rtd_filter #(
    .AVG_LOG2   (2),
    .FAULT_LIMIT(3)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
  task automatic applyStimulus(input logic [15:0] d, input logic v, input logic c);
    bus.rtd_data  = d;
    bus.rtd_valid = v;
    bus.fault_clr = c;
    @(posedge clk);
    #1;
    bus.rtd_valid = 1'b0;
    bus.fault_clr = 1'b0;
  endtask

  task automatic send_good(input int code, input logic exp_valid);
    applyStimulus(16'(code << 1), 1'b1, 1'b0);
    checkOutput("avg_valid", int'(bus.avg_valid), int'(exp_valid));
  endtask

  task automatic send_fault(input logic clr, input int exp_cnt, input logic exp_latch);
    applyStimulus(16'h4001, 1'b1, clr);
    checkOutput("fault_cnt", int'(bus.fault_cnt), exp_cnt);
    checkOutput("fault_latched", int'(bus.fault_latched), int'(exp_latch));
    checkOutput("avg_valid", int'(bus.avg_valid), 0);
  endtask

  task automatic expect_avg(input int avg, input int temp);
    exp_t e;
    e.avg  = avg;
    e.temp = temp;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst avg_code", int'(bus.avg_code), 0);
    checkOutput("rst temp_x16", int'(bus.temp_x16), 0);
    checkOutput("rst avg_valid", int'(bus.avg_valid), 0);
    checkOutput("rst fault_latched", int'(bus.fault_latched), 0);
    checkOutput("rst fault_cnt", int'(bus.fault_cnt), 0);
  endtask

  // Monitor: every avg_valid pulse must match the oldest expected average.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.avg_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected avg_valid: got avg_code %0d expected no pulse", bus.avg_code);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("sb avg_code", int'(bus.avg_code), e.avg);
          checkOutput("sb temp_x16", int'(bus.temp_x16), e.temp);
        end
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rstn          = 1'b0;
    bus.rtd_data  = 16'h0;
    bus.rtd_valid = 1'b0;
    bus.fault_clr = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: four identical codes average to themselves
    expect_avg(8192, 0);
    for (int i = 0; i < 3; i++) send_good(8192, 1'b0);
    send_good(8192, 1'b1);

    // 2: truncating average and negative temperature
    expect_avg(8001, -96);
    for (int i = 0; i < 3; i++) send_good(8000 + i, 1'b0);
    send_good(8003, 1'b1);
    checkOutput("hold avg_code", int'(bus.avg_code), 8001);
    applyStimulus(16'h0, 1'b0, 1'b0);
    checkOutput("hold temp_x16", int'(bus.temp_x16), -96);

    // 3: three consecutive faults latch; samples are ignored until cleared
    send_fault(1'b0, 1, 1'b0);
    send_fault(1'b0, 2, 1'b0);
    send_fault(1'b0, 3, 1'b1);
    for (int i = 0; i < 4; i++) send_good(8192, 1'b0);
    checkOutput("faulted fault_cnt", int'(bus.fault_cnt), 3);
    applyStimulus(16'h0, 1'b0, 1'b1);
    checkOutput("clr fault_latched", int'(bus.fault_latched), 0);
    checkOutput("clr fault_cnt", int'(bus.fault_cnt), 0);

    // 4: interleaved faults never accumulate past one
    expect_avg(8192, 0);
    send_fault(1'b0, 1, 1'b0);
    send_good(8192, 1'b0);
    checkOutput("interleave fault_cnt", int'(bus.fault_cnt), 0);
    send_fault(1'b0, 1, 1'b0);
    send_good(8192, 1'b0);
    send_fault(1'b0, 1, 1'b0);
    send_good(8192, 1'b0);
    send_good(8192, 1'b1);
    send_good(8192, 1'b0);

    // 5: reset mid-block discards the partial sum
    send_good(8192, 1'b0);
    send_good(8192, 1'b0);
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    expect_avg(100, -4046);
    for (int i = 0; i < 3; i++) send_good(100, 1'b0);
    send_good(100, 1'b1);

    // 6: clear wins over a simultaneous sample while faulted
    send_fault(1'b0, 1, 1'b0);
    send_fault(1'b0, 2, 1'b0);
    send_fault(1'b0, 3, 1'b1);
    applyStimulus(16'h4000, 1'b1, 1'b1);
    checkOutput("clr+sample fault_latched", int'(bus.fault_latched), 0);
    checkOutput("clr+sample fault_cnt", int'(bus.fault_cnt), 0);
    expect_avg(8192, 0);
    for (int i = 0; i < 3; i++) send_good(8192, 1'b0);
    send_good(8192, 1'b1);

    // clear with a faulty sample in ACCUM leaves the count at one
    send_fault(1'b0, 1, 1'b0);
    send_fault(1'b1, 1, 1'b0);
    send_good(8192, 1'b0);
    checkOutput("good clears fault_cnt", int'(bus.fault_cnt), 0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
